pwm_duty_sampler: RTL and testbench

PWM_DUTY_SAMPLER -- requirements
Module: pwm_duty_sampler

---
 rtl/pwm_duty_sampler.sv | 123 ++++++++++++
 tb/tb_pwm_duty_sampler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_sampler.sv
// Per-channel PWM duty counter over fixed sample windows, with a buffered valid/ready output.
// Define PWM_SAMPLER_SKID_EN for a 2-entry output FIFO; otherwise a single output register is used.
module pwm_duty_sampler #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned SAMPLE_CYCLES = 2835,
  parameter int unsigned CNT_W         = $clog2(SAMPLE_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         pwm_in,
  input  logic                      enable,
  output logic [NUM_CH*CNT_W-1:0]   sample_data,
  output logic                      sample_valid,
  input  logic                      sample_ready,
  output logic                      overrun,
  input  logic                      overrun_clear
);

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(SAMPLE_CYCLES - 1);

  logic [CNT_W-1:0]        win_q, win_d;
  logic [CNT_W-1:0]        acc_q [NUM_CH];
  logic [CNT_W-1:0]        acc_d [NUM_CH];
  logic                    win_end;
  logic [NUM_CH*CNT_W-1:0] result;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    drop;

  // Accumulators fold in the window-end sample directly, so the result is complete on that edge.
  always_comb begin
    win_end = enable && (win_q == WIN_LAST);
    win_d   = '0;
    if (enable && !win_end) win_d = win_q + CNT_W'(1);
    result  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      result[i*CNT_W +: CNT_W] = acc_q[i] + CNT_W'(pwm_in[i]);
      acc_d[i] = (enable && !win_end) ? result[i*CNT_W +: CNT_W] : '0;
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (drop)               overrun_d = 1'b1;
    else if (overrun_clear) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q     <= '0;
      acc_q     <= '{default: '0};
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      win_q     <= win_d;
      acc_q     <= acc_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

`ifdef PWM_SAMPLER_SKID_EN
  logic [NUM_CH*CNT_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    pop, space;

  // Pop first, then push into the slot the pop left free; buf0 is always the head.
  always_comb begin
    pop    = (cnt_q != 2'd0) && sample_ready;
    space  = (cnt_q != 2'd2) || pop;
    drop   = win_end && !space;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    if (pop) begin
      buf0_d = buf1_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (win_end && space) begin
      if (cnt_d == 2'd0) buf0_d = result;
      else               buf1_d = result;
      cnt_d = cnt_d + 2'd1;
    end
    valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf0_q <= '0;
      buf1_q <= '0;
      cnt_q  <= '0;
    end else begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sample_data = buf0_q;
`else
  logic [NUM_CH*CNT_W-1:0] data_q, data_d;
  logic                    pop, push;

  always_comb begin
    pop     = valid_q && sample_ready;
    push    = win_end && (!valid_q || pop);
    drop    = win_end && valid_q && !pop;
    data_d  = push ? result : data_q;
    valid_d = push || (valid_q && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign sample_data = data_q;
`endif

endmodule

// File: tb/tb_pwm_duty_sampler.sv
// Directed self-checking bench for pwm_duty_sampler (NUM_CH=2, SAMPLE_CYCLES=10, CNT_W=4).
module tb_pwm_duty_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pwm_in;
  logic       enable;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       sample_ready;
  logic       overrun;
  logic       overrun_clear;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned mode     = 0;

`ifdef PWM_SAMPLER_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int unsigned OVR_EDGE  = SKID ? 30 : 20;
  localparam int unsigned DROP_EDGE = SKID ? 60 : 50;

  always #5 clk = ~clk;

  pwm_duty_sampler #(
    .NUM_CH        (2),
    .SAMPLE_CYCLES (10),
    .CNT_W         (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pwm_in        (pwm_in),
    .enable        (enable),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .overrun       (overrun),
    .overrun_clear (overrun_clear)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // k is the 1-based edge index since reset; pos is the position inside the window.
  function automatic logic [1:0] pwm_pat(input int unsigned k);
    int unsigned pos;
    int unsigned w;
    pos = (k - 1) % 10;
    w   = (k - 1) / 10 + 1;
    case (mode)
      1:       pwm_pat = {pos < 3, (pos % 2) == 0};
      2:       pwm_pat = {pos < w, 1'b1};
      default: pwm_pat = 2'b01;
    endcase
  endfunction

  task automatic tick();
    pwm_in = pwm_pat(cyc + 1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    rst           = 1'b1;
    pwm_in        = 2'b00;
    enable        = 1'b1;
    sample_ready  = 1'b1;
    overrun_clear = 1'b0;

    mode = 0;
    do_reset();
    check_val("rst_valid",   sample_valid, 0);
    check_val("rst_data",    sample_data,  0);
    check_val("rst_overrun", overrun,      0);

    // Constant ch0 high, ch1 low
    for (int unsigned k = 1; k <= 30; k++) begin
      tick();
      check_val("t1_valid", sample_valid, (k % 10) == 0);
      if ((k % 10) == 0) check_val("t1_data", sample_data, 8'h0A);
    end
    check_val("t1_overrun", overrun, 0);

    // ch0 toggling, ch1 high 3 of 10
    mode = 1;
    do_reset();
    for (int unsigned k = 1; k <= 30; k++) begin
      tick();
      check_val("t2_valid", sample_valid, (k % 10) == 0);
      if ((k % 10) == 0) check_val("t2_data", sample_data, 8'h35);
    end

    // Back-pressure: per-window distinct ch1 counts 1,2,3,4
    mode = 2;
    sample_ready = 1'b0;
    do_reset();
    for (int unsigned k = 1; k <= 40; k++) begin
      if (k == 36) sample_ready = 1'b1;
      tick();
      if (k >= 10 && k <= 35) begin
        check_val("t3_hold_valid", sample_valid, 1);
        check_val("t3_hold_data",  sample_data,  8'h1A);
      end
      if (k == OVR_EDGE - 1) check_val("t3_ovr_before", overrun, 0);
      if (k == OVR_EDGE)     check_val("t3_ovr_set",    overrun, 1);
      if (k == 36) begin
        check_val("t3_pop1_valid", sample_valid, SKID);
        if (SKID) check_val("t3_pop1_data", sample_data, 8'h2A);
      end
      if (k == 37) check_val("t3_drained", sample_valid, 0);
      if (k == 40) begin
        check_val("t3_next_valid", sample_valid, 1);
        check_val("t3_next_data",  sample_data,  8'h4A);
      end
    end

    // Overrun clear vs. coincident drop, then quiet clear
    sample_ready = 1'b0;
    for (int unsigned k = 41; k <= DROP_EDGE + 4; k++) begin
      overrun_clear = (k == DROP_EDGE) || (k == DROP_EDGE + 2);
      sample_ready  = (k >= DROP_EDGE + 3);
      tick();
      if (k == DROP_EDGE - 1) check_val("t4_ovr_sticky", overrun, 1);
      if (k == DROP_EDGE) begin
        check_val("t4_set_wins",  overrun,     1);
        check_val("t4_kept_head", sample_data, 8'h4A);
      end
      if (k == DROP_EDGE + 1) check_val("t4_ovr_hold",    overrun, 1);
      if (k == DROP_EDGE + 2) check_val("t4_ovr_cleared", overrun, 0);
      if (k == DROP_EDGE + 3) begin
        check_val("t4_after_pop_valid", sample_valid, SKID);
        if (SKID) check_val("t4_after_pop_data", sample_data, 8'h5A);
      end
    end
    overrun_clear = 1'b0;

    // Enable dropped at window cycle 6 for 4 cycles
    mode = 0;
    sample_ready = 1'b1;
    enable = 1'b1;
    do_reset();
    for (int unsigned k = 1; k <= 20; k++) begin
      if (k == 7)  enable = 1'b0;
      if (k == 11) enable = 1'b1;
      tick();
      if (k < 20) check_val("t5_no_partial", sample_valid, 0);
      else begin
        check_val("t5_valid", sample_valid, 1);
        check_val("t5_data",  sample_data,  8'h0A);
      end
    end

    // Reset mid-window while a sample is pending
    sample_ready = 1'b0;
    do_reset();
    for (int unsigned k = 1; k <= 17; k++) begin
      tick();
      if (k >= 10) check_val("t6_pending", sample_valid, 1);
    end
    rst = 1'b1;
    tick();
    check_val("t6_rst_valid",   sample_valid, 0);
    check_val("t6_rst_data",    sample_data,  0);
    check_val("t6_rst_overrun", overrun,      0);
    rst = 1'b0;
    sample_ready = 1'b1;
    cyc = 0;
    for (int unsigned k = 1; k <= 10; k++) begin
      tick();
      if (k < 10) check_val("t6_wait", sample_valid, 0);
      else begin
        check_val("t6_valid", sample_valid, 1);
        check_val("t6_data",  sample_data,  8'h0A);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
